// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: LED register, UART TX (FIFO + 8N1 serializer),
// UART status and a free-running cycle counter.
module io_bus_responder #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] IO_memAddr_i,
  input  logic [31:0] IO_memWData_i,
  input  logic        IO_memWr_i,
  output logic [31:0] IO_memRData_o,
  output logic [7:0]  leds_o,
  output logic        uartTx_o
);

  localparam int unsigned Depth  = 2 ** FIFO_AW;
  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  CountFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uartState_e;

  // Address decode
  logic [2:0] wordSel;
  logic       wrLeds, wrData, wrStatus, wrCycles;

  assign wordSel  = IO_memAddr_i[4:2];
  assign wrLeds   = IO_memWr_i && (wordSel == 3'd0);
  assign wrData   = IO_memWr_i && (wordSel == 3'd1);
  assign wrStatus = IO_memWr_i && (wordSel == 3'd2);
  assign wrCycles = IO_memWr_i && (wordSel == 3'd3);

  logic unusedAddrBits;
  assign unusedAddrBits = ^{IO_memAddr_i[31:5], IO_memAddr_i[1:0]};

  // LED register
  logic [7:0] ledsQ;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ledsQ <= 8'h00;
    end else if (wrLeds) begin
      ledsQ <= IO_memWData_i[7:0];
    end
  end

  assign leds_o = ledsQ;

  // TX FIFO
  logic [7:0]         fifoMem [Depth];
  logic [FIFO_AW-1:0] wrPtrQ, rdPtrQ;
  logic [FIFO_AW:0]   countQ;
  logic               fifoFull, fifoEmpty, push, pop, overflowQ;

  assign fifoFull  = (countQ == CountFull);
  assign fifoEmpty = (countQ == '0);
  // Fullness uses the pre-edge count, so a same-edge pop never makes room.
  assign push      = wrData && !fifoFull;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem[wrPtrQ] <= IO_memWData_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) begin
        wrPtrQ <= wrPtrQ + 1'b1;
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
      end
      case ({push, pop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflowQ <= 1'b0;
    end else if (wrData && fifoFull) begin
      overflowQ <= 1'b1;
    end else if (wrStatus && IO_memWData_i[3]) begin
      overflowQ <= 1'b0;
    end
  end

  // 8N1 serializer
  uartState_e        stateQ, stateD;
  logic [7:0]        shiftQ, shiftD;
  logic [2:0]        bitIdxQ, bitIdxD;
  logic [TimerW-1:0] timerQ, timerD;
  logic              txQ, txD, timerDone;

  assign timerDone = (timerQ == TimerMax);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stateQ  <= StIdle;
      shiftQ  <= 8'h00;
      bitIdxQ <= 3'd0;
      timerQ  <= '0;
      txQ     <= 1'b1;
    end else begin
      stateQ  <= stateD;
      shiftQ  <= shiftD;
      bitIdxQ <= bitIdxD;
      timerQ  <= timerD;
      txQ     <= txD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    shiftD  = shiftQ;
    bitIdxD = bitIdxQ;
    timerD  = timerQ;
    txD     = txQ;
    pop     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (!fifoEmpty) begin
          pop    = 1'b1;
          shiftD = fifoMem[rdPtrQ];
          txD    = 1'b0;
          timerD = '0;
          stateD = StStart;
        end
      end
      StStart: begin
        if (timerDone) begin
          timerD  = '0;
          txD     = shiftQ[0];
          bitIdxD = 3'd0;
          stateD  = StData;
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      StData: begin
        if (timerDone) begin
          timerD = '0;
          if (bitIdxQ == 3'd7) begin
            txD    = 1'b1;
            stateD = StStop;
          end else begin
            // shiftQ[0] is on the line; the next bit sits at [1].
            txD     = shiftQ[1];
            shiftD  = shiftQ >> 1;
            bitIdxD = bitIdxQ + 3'd1;
          end
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      StStop: begin
        if (timerDone) begin
          timerD = '0;
          stateD = StIdle;
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign uartTx_o = txQ;

  // Cycle counter
  logic [31:0] cyclesQ;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cyclesQ <= 32'd0;
    end else if (wrCycles) begin
      cyclesQ <= IO_memWData_i;
    end else begin
      cyclesQ <= cyclesQ + 32'd1;
    end
  end

  // Read path
  logic [31:0] count32;
  logic [3:0]  countField;
  logic [7:0]  status;

  assign count32    = 32'(countQ);
  assign countField = (count32 > 32'd15) ? 4'hF : count32[3:0];
  assign status     = {countField, overflowQ, fifoEmpty, fifoFull, (stateQ != StIdle)};

  always_comb begin
    IO_memRData_o = 32'd0;
    case (wordSel)
      3'd0:    IO_memRData_o = {24'd0, ledsQ};
      3'd2:    IO_memRData_o = {24'd0, status};
      3'd3:    IO_memRData_o = cyclesQ;
      default: IO_memRData_o = 32'd0;
    endcase
  end

endmodule
